// File: rtl/reg_serial_tx_pkg.sv
// reg_serial_tx shared types and constants.
// Holds the FSM encoding, default sizes and the counter-width helper.
package reg_serial_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int DIV_DEF        = 2;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_serial_tx_div.sv
// DIV-cycle tick generator for reg_serial_tx.
// Held at zero by clr; tick is high on the DIV-th cycle after a clear.
module reg_serial_tx_div
    import reg_serial_tx_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk,
    input  logic Rn,
    input  logic clr,
    output logic tick
);

    localparam int CW = clog2(DIV) + 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == CW'(DIV - 1));

endmodule

// File: rtl/reg_serial_tx.sv
// Parallel-to-serial transmitter for 74HC595-style register chains.
// Define REG_SERIAL_TX_LSB_FIRST_EN to send din[0] first (default MSB first).
module reg_serial_tx
    import reg_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DIV        = DIV_DEF
) (
    input  logic                  clk,
    input  logic                  Rn,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  sdat,
    output logic                  lat
);

    localparam int BW = clog2(DATA_WIDTH) + 1;

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shift;
    logic [BW-1:0]         bit_cnt;
    logic                  tick;
    logic                  clr;

    // Divider restarts on every state change; idle keeps it parked at zero.
    assign clr = (state == IDLE) || tick;

    reg_serial_tx_div #(
        .DIV (DIV)
    ) u_div (
        .clk  (clk),
        .Rn   (Rn),
        .clr  (clr),
        .tick (tick)
    );

`ifdef REG_SERIAL_TX_LSB_FIRST_EN
    assign sdat  = shreg[0];
    assign shift = {1'b0, shreg[DATA_WIDTH-1:1]};
`else
    assign sdat  = shreg[DATA_WIDTH-1];
    assign shift = {shreg[DATA_WIDTH-2:0], 1'b0};
`endif

    always_ff @(posedge clk or negedge Rn) begin
        if (!Rn) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            lat     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= din;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        state <= HI;
                    end
                end
                HI: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            // Clearing the shifter forces sdat low while latching.
                            shreg <= '0;
                            lat   <= 1'b1;
                            state <= LATCH;
                        end else begin
                            shreg   <= shift;
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        lat   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Self-checking bench for reg_serial_tx.
// Random frames are compared with a frame-level model of the serial link.
module tb_reg_serial_tx;

    localparam int W        = 8;
    localparam int D        = 2;
    localparam int BUSY_LEN = 2 * D * W + D;

    logic         clk;
    logic         Rn;
    logic         start;
    logic [W-1:0] din;
    logic         busy;
    logic         done;
    logic         sclk;
    logic         sdat;
    logic         lat;

    int checks;
    int errors;

    reg_serial_tx #(
        .DATA_WIDTH (W),
        .DIV        (D)
    ) dut (
        .clk   (clk),
        .Rn    (Rn),
        .start (start),
        .din   (din),
        .busy  (busy),
        .done  (done),
        .sclk  (sclk),
        .sdat  (sdat),
        .lat   (lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed link activity, sampled mid-cycle.
    int          cyc;
    int          rises;
    int          lat_pulses;
    int          lat_cycles;
    int          busy_cycles;
    int          done_pulses;
    int          bad_done;
    int          bad_stab;
    int          last_rise;
    int          lat_rise;
    logic [31:0] rx_word;
    logic        p_sclk;
    logic        p_lat;
    logic        p_busy;
    logic        p_sdat;

    initial begin
        cyc = 0;
        p_sclk = 0;
        p_lat = 0;
        p_busy = 0;
        p_sdat = 0;
    end

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (sclk && !p_sclk) begin
            rises = rises + 1;
            rx_word = {rx_word[30:0], sdat};
            last_rise = cyc;
            if (sdat != p_sdat) bad_stab = bad_stab + 1;
        end
        if (lat && !p_lat) begin
            lat_pulses = lat_pulses + 1;
            lat_rise = cyc;
        end
        if (lat) lat_cycles = lat_cycles + 1;
        if (busy) busy_cycles = busy_cycles + 1;
        if (done) done_pulses = done_pulses + 1;
        if (Rn) begin
            if (done && busy) bad_done = bad_done + 1;
            if (done && !p_busy) bad_done = bad_done + 1;
            if (p_busy && !busy && !done) bad_done = bad_done + 1;
        end
        p_sclk = sclk;
        p_lat = lat;
        p_busy = busy;
        p_sdat = sdat;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit order on the wire, as a word received MSB-of-time first.
    function automatic logic [W-1:0] wire_order(input logic [W-1:0] d);
        logic [W-1:0] r;
`ifdef REG_SERIAL_TX_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[W-1-i] = d[i];
`else
        r = d;
`endif
        return r;
    endfunction

    function automatic logic first_bit(input logic [W-1:0] d);
        logic [W-1:0] r;
        r = wire_order(d);
        return r[W-1];
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        rises = 0;
        lat_pulses = 0;
        lat_cycles = 0;
        busy_cycles = 0;
        done_pulses = 0;
        bad_done = 0;
        bad_stab = 0;
        last_rise = 0;
        lat_rise = 0;
        rx_word = '0;
    endtask

    task automatic wait_dones(input int n, input int bound);
        int k;
        k = 0;
        while (done_pulses < n && k < bound) begin
            step(1);
            k++;
        end
        if (done_pulses < n) chk("timeout_done", 32'(done_pulses), 32'(n));
    endtask

    task automatic launch(input logic [W-1:0] d, input string tag);
        din = d;
        start = 1'b1;
        step(1);
        start = 1'b0;
        din = $urandom;
        chk({tag, "_acc_busy"}, 32'(busy), 32'd1);
        chk({tag, "_acc_sclk"}, 32'(sclk), 32'd0);
        chk({tag, "_acc_sdat"}, 32'(sdat), 32'(first_bit(d)));
    endtask

    task automatic frame_checks(input logic [W-1:0] d, input string tag);
        step(2);
        chk({tag, "_bits"}, rx_word, 32'(wire_order(d)));
        chk({tag, "_rises"}, 32'(rises), 32'(W));
        chk({tag, "_busy_len"}, 32'(busy_cycles), 32'(BUSY_LEN));
        chk({tag, "_lat_len"}, 32'(lat_cycles), 32'(D));
        chk({tag, "_lat_pulses"}, 32'(lat_pulses), 32'd1);
        chk({tag, "_lat_delay"}, 32'(lat_rise - last_rise), 32'(D));
        chk({tag, "_done"}, 32'(done_pulses), 32'd1);
        chk({tag, "_done_edge"}, 32'(bad_done), 32'd0);
        chk({tag, "_stable"}, 32'(bad_stab), 32'd0);
    endtask

    initial begin
        logic [W-1:0] d;
        int k;
        checks = 0;
        errors = 0;
        clear_stats();

        Rn = 1'b0;
        start = 1'b1;
        din = 8'hFF;
        step(5);
        chk("rst_outputs", 32'({busy, done, sclk, sdat, lat}), 32'd0);
        chk("rst_no_sclk", 32'(rises), 32'd0);
        start = 1'b0;
        Rn = 1'b1;
        step(5);
        chk("rst_idle_busy", 32'(busy), 32'd0);
        chk("rst_idle_sclk", 32'(rises), 32'd0);

        clear_stats();
        launch(8'hA5, "a5");
        wait_dones(1, 100);
        frame_checks(8'hA5, "a5");

        for (int i = 0; i < 6; i++) begin
            d = $urandom;
            clear_stats();
            step($urandom_range(0, 3));
            launch(d, "rnd");
            wait_dones(1, 100);
            frame_checks(d, "rnd");
        end

        clear_stats();
        launch(8'h00, "ign");
        step(8);
        din = 8'hFF;
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_dones(1, 100);
        frame_checks(8'h00, "ign");
        step(60);
        chk("ign_no_second_done", 32'(done_pulses), 32'd1);
        chk("ign_no_second_sclk", 32'(rises), 32'(W));

        clear_stats();
        din = 8'h3C;
        start = 1'b1;
        step(1);
        din = 8'hC3;
        wait_dones(1, 100);
        start = 1'b0;
        chk("b2b_gapless", 32'(busy), 32'd1);
        wait_dones(2, 100);
        step(2);
        chk("b2b_bits", rx_word,
            32'({wire_order(8'h3C), wire_order(8'hC3)}));
        chk("b2b_rises", 32'(rises), 32'(2 * W));
        chk("b2b_lat_pulses", 32'(lat_pulses), 32'd2);
        chk("b2b_busy_len", 32'(busy_cycles), 32'(2 * BUSY_LEN));
        chk("b2b_done_edge", 32'(bad_done), 32'd0);

        clear_stats();
        d = $urandom;
        launch(d, "mid");
        k = 0;
        while (rises < 4 && k < 100) begin
            step(1);
            k++;
        end
        chk("mid_reach_4", 32'(rises), 32'd4);
        Rn = 1'b0;
        #1;
        chk("mid_outputs", 32'({busy, done, sclk, sdat, lat}), 32'd0);
        step(3);
        Rn = 1'b1;
        step(60);
        chk("mid_no_lat", 32'(lat_pulses), 32'd0);
        chk("mid_no_done", 32'(done_pulses), 32'd0);
        chk("mid_no_restart", 32'(rises), 32'd4);
        chk("mid_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
